// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one single-port synchronous RAM.
// Latency: request seen in IDLE is granted at that edge; done strobes 3 edges later (4 cycles/txn).
// Backpressure: the losing requester keeps req high and stays pending until granted; nothing is dropped.
module mem_arbiter (
  input  logic        clock,
  input  logic        clear,
  // port 0: instruction fetch
  input  logic        req0,
  input  logic [7:0]  addr0,
  input  logic [31:0] wdata0,
  input  logic        we0,
  output logic [31:0] rdata0,
  output logic        done0,
  // port 1: data access
  input  logic        req1,
  input  logic [7:0]  addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  output logic [31:0] rdata1,
  output logic        done1,
  // RAM side
  output logic [7:0]  ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  // status
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ram_address_q, ram_address_d;
  logic [31:0] ram_data_q, ram_data_d;
  logic        ram_wren_q, ram_wren_d;
  // Direction of the granted transaction; ram_wren itself drops after ISSUE,
  // so CAPTURE needs its own copy to know whether to load rdata.
  logic        we_q, we_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        owner_q, owner_d;
  logic        busy_q, busy_d;
  // Port served by the most recent grant; a tie goes to the other one.
  logic        last_q, last_d;
  logic        pick1;

  // Winner selection: a sole requester always wins, a tie goes to the port not served last.
  always_comb begin
    pick1 = req1 & (~req0 | ~last_q);
  end

  // Next-state and next-output computation for the four-phase transaction.
  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = ram_wren_q;
    we_d          = we_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    done0_d       = done0_q;
    done1_d       = done1_q;
    owner_d       = owner_q;
    last_d        = last_q;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // Request fields are captured here only; later changes on the
          // port do not affect this transaction.
          owner_d       = pick1;
          last_d        = pick1;
          ram_address_d = pick1 ? addr1  : addr0;
          ram_data_d    = pick1 ? wdata1 : wdata0;
          ram_wren_d    = pick1 ? we1    : we0;
          we_d          = pick1 ? we1    : we0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        // RAM samples address/data/wren at the end of this cycle.
        ram_wren_d = 1'b0;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        // ram_q now reflects the address sampled at the end of ISSUE.
        if (!we_q) begin
          if (owner_q) rdata1_d = ram_q;
          else         rdata0_d = ram_q;
        end
        if (owner_q) done1_d = 1'b1;
        else         done0_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done0_d = 1'b0;
        done1_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        ram_wren_d = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; clear overrides everything and abandons any transaction.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= IDLE;
      ram_address_q <= 8'd0;
      ram_data_q    <= 32'd0;
      ram_wren_q    <= 1'b0;
      we_q          <= 1'b0;
      rdata0_q      <= 32'd0;
      rdata1_q      <= 32'd0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      owner_q       <= 1'b0;
      busy_q        <= 1'b0;
      last_q        <= 1'b1;  // port 0 wins the first tie
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      we_q          <= we_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      owner_q       <= owner_d;
      busy_q        <= busy_d;
      last_q        <= last_d;
    end
  end

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign owner       = owner_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural synchronous RAM.
// Latency: req raised just after an edge -> done expected 3 edges later.
// Backpressure: losing port holds req; bench drops req in the DONE cycle.
module tb_mem_arbiter;

  logic        clock;
  logic        clear;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        done0, done1;
  logic [7:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic        busy, owner;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clock(clock), .clear(clear),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .rdata0(rdata0), .done0(done0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .rdata1(rdata1), .done1(done1),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: q is the word at the address sampled on the previous edge.
  logic [31:0] mem [256];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  // Invariants checked every cycle.
  always @(negedge clock) begin
    if (done0 === 1'b1 && done1 === 1'b1) begin
      errors++;
      $display("FAIL both_done actual=done0=1,done1=1 required=at most one");
    end
    if (ram_wren === 1'b1 && busy !== 1'b1) begin
      errors++;
      $display("FAIL wren_idle actual=ram_wren=1,busy=%b required=ram_wren only while busy", busy);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_address"}, {24'd0, ram_address}, 32'd0);
    chk({tag, "_ram_data"}, ram_data, 32'd0);
    chk({tag, "_ram_wren"}, {31'd0, ram_wren}, 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
    chk({tag, "_done0"}, {31'd0, done0}, 32'd0);
    chk({tag, "_done1"}, {31'd0, done1}, 32'd0);
    chk({tag, "_owner"}, {31'd0, owner}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_clear();
    @(posedge clock); #1;
    clear = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  // Step edges until a done strobe; cyc counts edges since the call.
  task automatic wait_done(input int budget, output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clock); #1;
      if (done0 === 1'b1) begin who = 0; cyc = c; break; end
      if (done1 === 1'b1) begin who = 1; cyc = c; break; end
    end
  endtask

  // One single-port transaction with latency, ownership and read-data checks.
  task automatic do_txn(input int port, input logic we, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [31:0] e0,
                        input logic [31:0] e1, input string tag);
    int who, cyc;
    @(posedge clock); #1;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    wait_done(12, who, cyc);
    chk({tag, "_who"}, who, port);
    chk({tag, "_lat"}, cyc, 3);
    chk({tag, "_owner"}, {31'd0, owner}, port);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_rdata0"}, rdata0, e0);
    chk({tag, "_rdata1"}, rdata1, e1);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clock); #1;
    chk({tag, "_done_drop"}, {30'd0, done1, done0}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int who, cyc;

    vecs[0] = '{0, 1'b1, 8'h00, 32'hA5A5A5A5, 32'h00000000, 32'h00000000};
    vecs[1] = '{0, 1'b0, 8'h00, 32'h00000000, 32'hA5A5A5A5, 32'h00000000};
    vecs[2] = '{1, 1'b1, 8'h01, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000000};
    vecs[3] = '{1, 1'b0, 8'h01, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[4] = '{0, 1'b0, 8'h01, 32'h00000000, 32'h5A5A5A5A, 32'h5A5A5A5A};
    vecs[5] = '{1, 1'b1, 8'h03, 32'h33333333, 32'h5A5A5A5A, 32'h5A5A5A5A};
    vecs[6] = '{1, 1'b1, 8'h04, 32'h44444444, 32'h5A5A5A5A, 32'h5A5A5A5A};
    vecs[7] = '{1, 1'b0, 8'h03, 32'h00000000, 32'h5A5A5A5A, 32'h33333333};

    clear = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("rst");
    clear = 1'b0;

    // Single-port transactions from the table.
    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_r0, vecs[i].exp_r1, $sformatf("vec%0d", i));

    // Simultaneous requests right after clear: port 0 first, port 1 four cycles later.
    do_clear();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h01;
    wait_done(12, who, cyc);
    chk("tie1_who", who, 0);
    chk("tie1_lat", cyc, 3);
    chk("tie1_rdata0", rdata0, 32'hA5A5A5A5);
    chk("tie1_rdata1", rdata1, 32'h00000000);
    req0 = 1'b0;
    wait_done(12, who, cyc);
    chk("tie2_who", who, 1);
    chk("tie2_gap", cyc, 4);
    chk("tie2_rdata1", rdata1, 32'h5A5A5A5A);
    chk("tie2_rdata0", rdata0, 32'hA5A5A5A5);
    req1 = 1'b0;
    @(posedge clock); #1;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(12, who, cyc);
    chk("tie3_who", who, 0);
    req0 = 1'b0;
    wait_done(12, who, cyc);
    chk("tie4_who", who, 1);
    req1 = 1'b0;
    @(posedge clock); #1;

    // Both ports hold req continuously: strict alternation 0,1,0,1.
    do_clear();
    req0 = 1'b1; addr0 = 8'h00; req1 = 1'b1; addr1 = 8'h01;
    for (int k = 0; k < 4; k++) begin
      wait_done(12, who, cyc);
      chk($sformatf("alt%0d_who", k), who, k % 2);
      chk($sformatf("alt%0d_gap", k), cyc, (k == 0) ? 3 : 4);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clock); #1;
    chk("alt_idle", {31'd0, busy}, 32'd0);

    // Clear during CAPTURE of a read: no done, everything back to reset values.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
    @(posedge clock); #1;   // ISSUE
    @(posedge clock); #1;   // CAPTURE
    clear = 1'b1; req0 = 1'b0;
    @(posedge clock); #1;
    chk_reset_outputs("clrcap");
    clear = 1'b0;

    // Clear during ISSUE of a write: the write still lands in the RAM.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h02; wdata0 = 32'h12345678;
    @(posedge clock); #1;   // ISSUE
    chk("clriss_wren", {31'd0, ram_wren}, 32'd1);
    clear = 1'b1; req0 = 1'b0;
    @(posedge clock); #1;
    chk("clriss_busy", {31'd0, busy}, 32'd0);
    chk("clriss_wren_off", {31'd0, ram_wren}, 32'd0);
    clear = 1'b0;
    wait_done(6, who, cyc);
    chk("clriss_no_done", who, -1);
    do_txn(0, 1'b0, 8'h02, 32'h0, 32'h12345678, 32'h00000000, "clriss_read");

    // Address change after grant is ignored: RAM sees 0x03 only.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
    @(posedge clock); #1;   // ISSUE
    chk("late_addr_issue", {24'd0, ram_address}, 32'h03);
    addr0 = 8'h04;
    @(posedge clock); #1;   // CAPTURE
    chk("late_addr_capture", {24'd0, ram_address}, 32'h03);
    wait_done(6, who, cyc);
    chk("late_addr_who", who, 0);
    chk("late_addr_rdata0", rdata0, 32'h33333333);
    req0 = 1'b0;
    @(posedge clock); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
